// File: rtl/rr_arb_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb_pkg
// Shared definitions for the round-robin request arbiter that feeds the
// 4-to-2 encoder: requester count, pointer width, FSM state type and a
// one-hot helper.
// -----------------------------------------------------------------------------
package rr_arb_pkg;

    // Only N = 4 is supported in this release; PTR_W must equal log2(N).
    localparam int N     = 4;
    localparam int PTR_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // One-hot vector with bit idx set.
    function automatic logic [N-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [N-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational selection of the next requester to grant.
//   pending_i  [N-1:0]      sticky request vector
//   last_ptr_i [PTR_W-1:0]  index granted last time
//   pick_idx_o [PTR_W-1:0]  selected requester (valid when pick_any_o=1)
//   pick_any_o              at least one request is pending
// Default build: round-robin, searching upward from last_ptr_i+1 with wrap.
// With RR_ARB_FIXED_PRIO_EN defined: highest set pending bit wins and
// last_ptr_i is ignored.
// -----------------------------------------------------------------------------
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N-1:0]     pending_i,
    input  logic [PTR_W-1:0] last_ptr_i,
    output logic [PTR_W-1:0] pick_idx_o,
    output logic             pick_any_o
);

    assign pick_any_o = |pending_i;

`ifdef RR_ARB_FIXED_PRIO_EN

    // Pointer is kept by the top level but plays no part in a fixed-priority pick.
    logic unused_last_ptr;
    assign unused_last_ptr = ^last_ptr_i;

    always_comb begin
        pick_idx_o = '0;
        // Ascending scan so the highest set bit is the final assignment.
        for (int i = 0; i < N; i++) begin
            if (pending_i[i]) begin
                pick_idx_o = PTR_W'(i);
            end
        end
    end

`else

    // cand_idx[k] is the k-th position searched; adding in PTR_W bits gives
    // the modulo-N wrap for free since N is a power of two.
    logic [PTR_W-1:0] cand_idx [N];
    logic [N-1:0]     rot_req;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign cand_idx[gi] = last_ptr_i + PTR_W'(gi + 1);
            assign rot_req[gi]  = pending_i[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        pick_idx_o = '0;
        // Descending scan so the nearest candidate after last_ptr wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                pick_idx_o = cand_idx[i];
            end
        end
    end

`endif

endmodule

// File: rtl/rr_req_arbiter.sv
// -----------------------------------------------------------------------------
// rr_req_arbiter
// Captures sticky request pulses from N sources and issues one one-hot grant
// at a time with a valid/ready handshake. The one-hot gnt drives the 4-to-2
// encoder directly, so at most one gnt bit is ever high.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        [N-1:0] request pulses, OR-ed into pending every edge
//   gnt_ready  downstream accepts the current grant (ignored while idle)
//   gnt        [N-1:0] one-hot grant, zero when gnt_valid=0
//   gnt_valid  gnt holds a valid grant
//   pending    [N-1:0] registered sticky request vector
// Build option: RR_ARB_FIXED_PRIO_EN selects fixed priority (bit N-1 highest)
// instead of round-robin; ports and timing are the same in both builds.
// -----------------------------------------------------------------------------
module rr_req_arbiter
    import rr_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         gnt_ready,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic [N-1:0] pending
);

    state_t           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [PTR_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [PTR_W-1:0] last_ptr_q, last_ptr_d;
    logic [N-1:0]     clr_mask;

    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;

    // The pick sees only the registered pending vector, so a request arriving
    // on the same edge as a pick is considered one cycle later.
    rr_pick u_pick (
        .pending_i  (pending_q),
        .last_ptr_i (last_ptr_q),
        .pick_idx_o (pick_idx),
        .pick_any_o (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        last_ptr_d  = last_ptr_q;
        clr_mask    = '0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d       = onehot(pick_idx);
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = pick_idx;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                // Returning to IDLE on accept creates the mandatory bubble.
                if (gnt_ready) begin
                    clr_mask    = gnt_q;
                    last_ptr_d  = gnt_idx_q;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // OR-ing req after the clear lets a same-edge re-request survive.
        pending_d = (pending_q & ~clr_mask) | req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            last_ptr_q  <= PTR_W'(N - 1);
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            last_ptr_q  <= last_ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_req_arbiter
// Self-checking bench for rr_req_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model that
// tracks pending requests as an integer set, the current grant as an index
// (-1 when none) and the last granted index.
// -----------------------------------------------------------------------------
module tb_rr_req_arbiter;
    import rr_arb_pkg::*;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         gnt_ready;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [N-1:0] pending;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state.
    int m_pend = 0;
    int m_gidx = -1;
    int m_last = N - 1;

    rr_req_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt_ready (gnt_ready),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    // Next requester according to the arbitration rule; -1 when nothing pending.
    function automatic int ref_pick(input int pend, input int last);
`ifdef RR_ARB_FIXED_PRIO_EN
        for (int k = N - 1; k >= 0; k--) begin
            if (pend[k]) return k;
        end
`else
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (pend[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    // Apply one cycle of inputs, advance the model, compare all outputs.
    task automatic step(input logic [N-1:0] r, input logic rdy, input logic rs);
        req       = r;
        gnt_ready = rdy;
        rst       = rs;
        @(posedge clk);
        if (rs) begin
            m_pend = 0;
            m_gidx = -1;
            m_last = N - 1;
        end else if (m_gidx < 0) begin
            m_gidx = ref_pick(m_pend, m_last);
            m_pend = m_pend | int'(r);
        end else if (rdy) begin
            $display("cycle %0d: grant %0d accepted", cyc, m_gidx);
            m_last = m_gidx;
            m_pend = (m_pend & ~(1 << m_gidx)) | int'(r);
            m_gidx = -1;
        end else begin
            m_pend = m_pend | int'(r);
        end
        #1;
        check("gnt_valid", 32'(gnt_valid), (m_gidx >= 0) ? 32'd1 : 32'd0);
        check("gnt", 32'(gnt), (m_gidx >= 0) ? (32'd1 << m_gidx) : 32'd0);
        check("pending", 32'(pending), 32'(m_pend));
        cyc++;
    endtask

    logic [N-1:0] seq_q[$];
    logic [N-1:0] seq_exp[4];

    initial begin
        req       = '0;
        gnt_ready = 1'b0;
        rst       = 1'b1;

        // Reset held with all requests high: nothing may be captured.
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b1);

        // One burst of all four requests, always ready: four grants in order.
        step(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(4'b0000, 1'b1, 1'b0);
            if (gnt_valid) seq_q.push_back(gnt);
        end
`ifdef RR_ARB_FIXED_PRIO_EN
        seq_exp = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
`else
        seq_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
        check("burst_count", 32'(seq_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < seq_q.size(); i++) begin
            check("burst_order", 32'(seq_q[i]), 32'(seq_exp[i]));
        end
        check("burst_drained", 32'(pending), 32'd0);

        // Backpressure: grant held for five cycles, then accepted.
        step(4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, 1'b0);
        check("bp_hold_gnt", 32'(gnt), 32'h4);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // Same-edge re-request on accept keeps the bit pending.
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        check("swc_pending", 32'(pending), 32'h2);
        step(4'b0000, 1'b0, 1'b0);
        check("swc_regrant", 32'(gnt), 32'h2);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // Wrap after granting bit 3.
        step(4'b1000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b1001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(4'b0000, 1'b1, 1'b0);

        // Reset while a grant is outstanding.
        step(4'b1100, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        check("rst_mid_valid", 32'(gnt_valid), 32'd0);
        step(4'b0000, 1'b0, 1'b0);

`ifdef RR_ARB_FIXED_PRIO_EN
        // Bit 3 re-requested on every accept monopolises the grant.
        step(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(gnt_valid ? 4'b1000 : 4'b0000, 1'b1, 1'b0);
        end
        for (int i = 0; i < 8; i++) step(4'b0000, 1'b1, 1'b0);
`endif

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] r;
            logic         rdy;
            logic         rs;
            r   = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
            rdy = ($urandom_range(0, 2) != 0);
            rs  = ($urandom_range(0, 79) == 0);
            step(r, rdy, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
